// File: rtl/fir_tap_mac.sv
// fir_tap_mac: serial multiply-accumulate stage of one equalizer band's FIR filter.
// One tap is processed per enabled cycle, indexed by the external tap counter.
// Each frame shifts one new sample into the delay line, accumulates TAPS
// products, and emits one rounded, saturated output sample.
//
// Ports:
//   clk            system clock, rising edge
//   rst            asynchronous active-low reset
//   clk_enable     tap strobe (same enable as the tap counter)
//   current_count  tap index k from the counter
//   sample_in      new sample, taken when clk_enable=1 and current_count=0
//   coeff_in       h[current_count] from the external coefficient ROM
//   y_out          filtered sample, held between updates
//   y_valid        one-cycle pulse when y_out updates
//   seq_error      sticky tap-count sequence violation flag
module fir_tap_mac #(
  parameter int DATA_W  = 16,
  parameter int COEFF_W = 16,
  parameter int TAPS    = 64,
  parameter int ACC_W   = 40,
  parameter int SHIFT   = 15
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clk_enable,
  input  logic [$clog2(TAPS)-1:0]  current_count,
  input  logic [DATA_W-1:0]        sample_in,
  input  logic [COEFF_W-1:0]       coeff_in,
  output logic [DATA_W-1:0]        y_out,
  output logic                     y_valid,
  output logic                     seq_error
);

  localparam int CNT_W  = $clog2(TAPS);
  localparam int PROD_W = DATA_W + COEFF_W;

  localparam logic [CNT_W-1:0] LAST_TAP = CNT_W'(TAPS - 1);

  localparam logic signed [ACC_W-1:0] ROUND_BIAS = ACC_W'(1) << (SHIFT - 1);
  localparam logic signed [ACC_W-1:0] SAT_MAX =
    {{(ACC_W - DATA_W + 1){1'b0}}, {(DATA_W - 1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN =
    {{(ACC_W - DATA_W + 1){1'b1}}, {(DATA_W - 1){1'b0}}};

  logic signed [DATA_W-1:0] x_q [TAPS];
  logic signed [ACC_W-1:0]  acc_q;
  logic [CNT_W-1:0]         expected_q;
  logic [DATA_W-1:0]        y_q;
  logic                     y_valid_q;
  logic                     seq_error_q;

  logic                     first_tap;
  logic                     last_tap;
  logic signed [DATA_W-1:0] tap_sample;
  logic signed [PROD_W-1:0] product;
  logic signed [ACC_W-1:0]  acc_base;
  logic signed [ACC_W-1:0]  acc_sum;
  logic signed [ACC_W-1:0]  rounded;
  logic signed [ACC_W-1:0]  shifted;
  logic [DATA_W-1:0]        y_sat;

  always_comb begin
    first_tap = (current_count == '0);
    last_tap  = (current_count == LAST_TAP);

    // At tap 0 the shifted-in x[0] is the incoming sample itself.
    tap_sample = first_tap ? $signed(sample_in) : x_q[current_count];
    product    = PROD_W'(tap_sample) * PROD_W'($signed(coeff_in));

    // Tap 0 restarts the accumulation, discarding the previous frame's sum.
    acc_base = first_tap ? '0 : acc_q;
    acc_sum  = acc_base + ACC_W'(product);

    // Round half up, then arithmetic shift out the coefficient fraction bits.
    rounded = acc_sum + ROUND_BIAS;
    shifted = rounded >>> SHIFT;

    if (shifted > SAT_MAX) begin
      y_sat = SAT_MAX[DATA_W-1:0];
    end else if (shifted < SAT_MIN) begin
      y_sat = SAT_MIN[DATA_W-1:0];
    end else begin
      y_sat = shifted[DATA_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < TAPS; i++) begin
        x_q[i] <= '0;
      end
      acc_q       <= '0;
      expected_q  <= '0;
      y_q         <= '0;
      y_valid_q   <= 1'b0;
      seq_error_q <= 1'b0;
    end else begin
      y_valid_q <= 1'b0;
      if (clk_enable) begin
        expected_q <= current_count + 1'b1;
        if (current_count != expected_q) begin
          seq_error_q <= 1'b1;
        end

        acc_q <= acc_sum;

        if (first_tap) begin
          for (int i = TAPS - 1; i > 0; i--) begin
            x_q[i] <= x_q[i-1];
          end
          x_q[0] <= $signed(sample_in);
        end

        if (last_tap) begin
          y_q       <= y_sat;
          y_valid_q <= 1'b1;
        end
      end
    end
  end

  assign y_out     = y_q;
  assign y_valid   = y_valid_q;
  assign seq_error = seq_error_q;

endmodule
